multi_axis_op_handler_fsm: RTL and testbench

//  Parametrised successor to the single-pair linear-op handler FSM. Sequences one motion op across up to
//  NUM_MOTORS motor channels selected by a per-op axis mask, waits for every selected motor to acknowledge
//  and finish, then pulses update_pos. Adds ack/finish timeouts, an abort path and a sticky error state.

---
 rtl/multi_axis_op_handler_fsm_pkg.sv | 27 ++
 rtl/multi_axis_op_handler_fsm_op_timeout_counter.sv | 48 ++++
 rtl/multi_axis_op_handler_fsm.sv | 194 +++++++++++++++++++
 tb/tb_multi_axis_op_handler_fsm.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/multi_axis_op_handler_fsm_pkg.sv
// Shared types for the multi-axis motion op handler: FSM states, error codes
// and the sizing helper for the timeout counter.
package motor_op_pkg;

  localparam int MAX_MOTORS = 8;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    TRIGGER    = 3'd1,
    WAIT       = 3'd2,
    UPDATE_POS = 3'd3,
    DONE       = 3'd4,
    ERROR      = 3'd5
  } op_state_e;

  typedef enum logic [1:0] {
    ERR_NONE         = 2'd0,
    ERR_ACK_TIMEOUT  = 2'd1,
    ERR_DONE_TIMEOUT = 2'd2
  } err_code_e;

  // Bits needed to hold 0..limit; at least one bit so a disabled timeout still elaborates.
  function automatic int cnt_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/multi_axis_op_handler_fsm_op_timeout_counter.sv
// Saturating tick counter for the ack/done timeouts. expired flags the tick on
// which the running count reaches the (runtime-selected) limit; a zero limit never expires.
module op_timeout_counter
  import motor_op_pkg::*;
#(
  parameter int LIMIT = 64
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        clk_en,
  input  logic                        clear,
  input  logic                        run,
  input  logic [cnt_width(LIMIT)-1:0] limit,
  output logic                        expired
);

  localparam int W = cnt_width(LIMIT);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;
  logic [W:0]   count_inc_s;

  // Next count and expiry; expiry counts the current tick so a limit of N allows N ticks.
  always_comb begin
    count_inc_s = {1'b0, count_q} + {{W{1'b0}}, 1'b1};
    expired     = run && (limit != {W{1'b0}}) && (count_inc_s >= {1'b0, limit});
    count_d     = count_q;
    if (clear) begin
      count_d = {W{1'b0}};
    end else if (run && !(&count_q)) begin
      count_d = count_inc_s[W-1:0];
    end else begin
      count_d = count_q;
    end
  end

  // Counter register: synchronous active-low reset, holds while clk_en is low.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_q <= {W{1'b0}};
    end else if (clk_en) begin
      count_q <= count_d;
    end else begin
      count_q <= count_q;
    end
  end

endmodule

// File: rtl/multi_axis_op_handler_fsm.sv
// Sequences one motion op across the motors selected by axis_mask: trigger,
// collect acks, collect finishes, pulse update_pos. Handles timeouts, abort and a sticky error.
module multi_axis_op_handler_fsm
  import motor_op_pkg::*;
#(
  parameter int NUM_MOTORS   = 2,
  parameter int ACK_TIMEOUT  = 64,
  parameter int DONE_TIMEOUT = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clk_en,
  input  logic                  trigger,
  input  logic [NUM_MOTORS-1:0] axis_mask,
  input  logic                  abort,
  input  logic                  err_clear,
  input  logic [NUM_MOTORS-1:0] motors_rdy,
  input  logic [NUM_MOTORS-1:0] motors_done,
  output logic [NUM_MOTORS-1:0] motors_trigger,
  output logic                  update_pos,
  output logic                  done,
  output logic                  rdy,
  output logic                  aborted,
  output logic                  error,
  output logic [1:0]            err_code
);

  localparam int TMAX = (ACK_TIMEOUT > DONE_TIMEOUT) ? ACK_TIMEOUT : DONE_TIMEOUT;
  localparam int CW   = cnt_width(TMAX);
  localparam logic [CW-1:0] ACK_LIM  = CW'(ACK_TIMEOUT);
  localparam logic [CW-1:0] DONE_LIM = CW'(DONE_TIMEOUT);
  localparam logic [NUM_MOTORS-1:0] ZERO_M = {NUM_MOTORS{1'b0}};

  op_state_e             state_q, state_d;
  logic [NUM_MOTORS-1:0] mask_q, mask_d;
  logic [NUM_MOTORS-1:0] ack_q, ack_d;
  logic [NUM_MOTORS-1:0] fin_q, fin_d;
  logic                  aborted_q, aborted_d;
  err_code_e             err_code_q, err_code_d;
  logic [NUM_MOTORS-1:0] motors_trigger_q, motors_trigger_d;
  logic                  update_pos_q, update_pos_d;
  logic                  done_q, done_d;
  logic                  rdy_q, rdy_d;
  logic                  error_q, error_d;

  logic                  accept_s;
  logic                  tmo_run_s;
  logic                  tmo_clear_s;
  logic                  tmo_expired_s;
  logic [CW-1:0]         tmo_limit_s;

  // A trigger is accepted only if no selected motor is busy.
  assign accept_s    = clk_en && trigger && (&(motors_rdy | ~axis_mask));
  assign tmo_run_s   = (state_q == TRIGGER) || (state_q == WAIT);
  assign tmo_limit_s = (state_q == WAIT) ? DONE_LIM : ACK_LIM;
  assign tmo_clear_s = (state_d != state_q);

  op_timeout_counter #(
    .LIMIT (TMAX)
  ) u_timeout (
    .clk     (clk),
    .reset_n (reset_n),
    .clk_en  (clk_en),
    .clear   (tmo_clear_s),
    .run     (tmo_run_s),
    .limit   (tmo_limit_s),
    .expired (tmo_expired_s)
  );

  // Next-state logic; priority within TRIGGER/WAIT is abort, then timeout, then progress.
  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    ack_d      = ack_q;
    fin_d      = fin_q;
    aborted_d  = aborted_q;
    err_code_d = err_code_q;
    if (clk_en) begin
      case (state_q)
        IDLE: begin
          if (accept_s) begin
            mask_d    = axis_mask;
            ack_d     = ZERO_M;
            fin_d     = ZERO_M;
            aborted_d = 1'b0;
            state_d   = (axis_mask == ZERO_M) ? UPDATE_POS : TRIGGER;
          end else begin
            state_d = IDLE;
          end
        end
        TRIGGER: begin
          ack_d = ack_q | (mask_q & ~motors_rdy);
          if (abort) begin
            aborted_d = 1'b1;
            state_d   = DONE;
          end else if (tmo_expired_s) begin
            err_code_d = ERR_ACK_TIMEOUT;
            state_d    = ERROR;
          end else if (ack_d == mask_q) begin
            state_d = WAIT;
          end else begin
            state_d = TRIGGER;
          end
        end
        WAIT: begin
          fin_d = fin_q | (ack_q & motors_done);
          if (abort) begin
            aborted_d = 1'b1;
            state_d   = DONE;
          end else if (tmo_expired_s) begin
            err_code_d = ERR_DONE_TIMEOUT;
            state_d    = ERROR;
          end else if (fin_d == mask_q) begin
            state_d = UPDATE_POS;
          end else begin
            state_d = WAIT;
          end
        end
        UPDATE_POS: state_d = DONE;
        DONE:       state_d = IDLE;
        ERROR: begin
          if (err_clear) begin
            err_code_d = ERR_NONE;
            state_d    = IDLE;
          end else begin
            state_d = ERROR;
          end
        end
        default: state_d = IDLE;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Output registers are loaded from the next state so they track the state register exactly.
  always_comb begin
    motors_trigger_d = ZERO_M;
    update_pos_d     = 1'b0;
    done_d           = 1'b0;
    rdy_d            = 1'b0;
    error_d          = 1'b0;
    case (state_d)
      IDLE: begin
        done_d = 1'b1;
        rdy_d  = 1'b1;
      end
      TRIGGER:    motors_trigger_d = mask_d & ~ack_d;
      WAIT:       done_d = 1'b0;
      UPDATE_POS: update_pos_d = 1'b1;
      DONE:       done_d = 1'b1;
      ERROR:      error_d = 1'b1;
      default:    done_d = 1'b0;
    endcase
  end

  // FSM, op bookkeeping and output registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q          <= IDLE;
      mask_q           <= ZERO_M;
      ack_q            <= ZERO_M;
      fin_q            <= ZERO_M;
      aborted_q        <= 1'b0;
      err_code_q       <= ERR_NONE;
      motors_trigger_q <= ZERO_M;
      update_pos_q     <= 1'b0;
      done_q           <= 1'b1;
      rdy_q            <= 1'b1;
      error_q          <= 1'b0;
    end else begin
      state_q          <= state_d;
      mask_q           <= mask_d;
      ack_q            <= ack_d;
      fin_q            <= fin_d;
      aborted_q        <= aborted_d;
      err_code_q       <= err_code_d;
      motors_trigger_q <= motors_trigger_d;
      update_pos_q     <= update_pos_d;
      done_q           <= done_d;
      rdy_q            <= rdy_d;
      error_q          <= error_d;
    end
  end

  assign motors_trigger = motors_trigger_q;
  assign update_pos     = update_pos_q;
  assign done           = done_q && !((state_q == IDLE) && accept_s);
  assign rdy            = rdy_q;
  assign aborted        = aborted_q;
  assign error          = error_q;
  assign err_code       = err_code_q;

endmodule

// File: tb/tb_multi_axis_op_handler_fsm.sv
// Directed scenarios plus random stimulus, checked every cycle against a phase-level reference model.
module tb_multi_axis_op_handler_fsm;

  localparam int NM = 2;
  localparam int AT = 4;
  localparam int DT = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n, clk_en, trigger, abort, err_clear;
  logic [NM-1:0] axis_mask, motors_rdy, motors_done, motors_trigger;
  logic          update_pos, done, rdy, aborted, error;
  logic [1:0]    err_code;

  multi_axis_op_handler_fsm #(
    .NUM_MOTORS   (NM),
    .ACK_TIMEOUT  (AT),
    .DONE_TIMEOUT (DT)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .clk_en         (clk_en),
    .trigger        (trigger),
    .axis_mask      (axis_mask),
    .abort          (abort),
    .err_clear      (err_clear),
    .motors_rdy     (motors_rdy),
    .motors_done    (motors_done),
    .motors_trigger (motors_trigger),
    .update_pos     (update_pos),
    .done           (done),
    .rdy            (rdy),
    .aborted        (aborted),
    .error          (error),
    .err_code       (err_code)
  );

  int vectors     = 0;
  int miscompares = 0;
  int upd_seen    = 0;
  bit checking    = 1'b0;

  // Reference model: which phase of the op we are in and what each motor has reported.
  typedef enum int {M_IDLE, M_ARMING, M_RUNNING, M_COMMIT, M_FINISH, M_FAULT} mphase_e;
  mphase_e       ph = M_IDLE;
  logic [NM-1:0] m_mask = '0, m_acked = '0, m_fin = '0;
  int            ticks = 0;
  logic          m_ab = 1'b0;
  logic [1:0]    m_ec = 2'd0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit accepts();
    if (!(clk_en && trigger)) return 1'b0;
    for (int i = 0; i < NM; i++)
      if (axis_mask[i] && !motors_rdy[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_tick();
    mphase_e nx;
    if (!reset_n) begin
      ph = M_IDLE; m_mask = '0; m_acked = '0; m_fin = '0; ticks = 0; m_ab = 1'b0; m_ec = 2'd0;
    end else if (clk_en) begin
      nx = ph;
      case (ph)
        M_IDLE: if (accepts()) begin
          m_mask = axis_mask; m_acked = '0; m_fin = '0; m_ab = 1'b0;
          nx = (axis_mask == '0) ? M_COMMIT : M_ARMING;
        end
        M_ARMING: begin
          ticks++;
          for (int i = 0; i < NM; i++) if (m_mask[i] && !motors_rdy[i]) m_acked[i] = 1'b1;
          if (abort) begin nx = M_FINISH; m_ab = 1'b1; end
          else if (AT != 0 && ticks >= AT) begin nx = M_FAULT; m_ec = 2'd1; end
          else if (m_acked == m_mask) nx = M_RUNNING;
        end
        M_RUNNING: begin
          ticks++;
          for (int i = 0; i < NM; i++) if (m_acked[i] && motors_done[i]) m_fin[i] = 1'b1;
          if (abort) begin nx = M_FINISH; m_ab = 1'b1; end
          else if (DT != 0 && ticks >= DT) begin nx = M_FAULT; m_ec = 2'd2; end
          else if (m_fin == m_mask) nx = M_COMMIT;
        end
        M_COMMIT: nx = M_FINISH;
        M_FINISH: nx = M_IDLE;
        M_FAULT:  if (err_clear) begin nx = M_IDLE; m_ec = 2'd0; end
        default:  nx = M_IDLE;
      endcase
      if (nx != ph) ticks = 0;
      ph = nx;
    end
  endtask

  // One clock: drive at the falling edge, check 1 time unit later, advance the model at the rising edge.
  task automatic step(input logic rn, input logic ce, input logic tr, input logic [NM-1:0] am,
                      input logic ab, input logic ec, input logic [NM-1:0] mr, input logic [NM-1:0] md);
    reset_n = rn; clk_en = ce; trigger = tr; axis_mask = am; abort = ab; err_clear = ec;
    motors_rdy = mr; motors_done = md;
    #1;
    if (checking) begin
      check("motors_trigger", 8'(motors_trigger), 8'((ph == M_ARMING) ? (m_mask & ~m_acked) : {NM{1'b0}}));
      check("update_pos", 8'(update_pos), 8'(ph == M_COMMIT));
      check("done", 8'(done), 8'((ph == M_IDLE) ? !accepts() : (ph == M_FINISH)));
      check("rdy", 8'(rdy), 8'(ph == M_IDLE));
      check("aborted", 8'(aborted), 8'(m_ab));
      check("error", 8'(error), 8'(ph == M_FAULT));
      check("err_code", 8'(err_code), 8'(m_ec));
    end
    if (update_pos === 1'b1) upd_seen++;
    @(posedge clk);
    model_tick();
    checking = 1'b1;
    @(negedge clk);
  endtask

  // Same inputs held for two disabled ticks, then one enabled tick.
  task automatic step3(input logic tr, input logic [NM-1:0] am, input logic [NM-1:0] mr,
                       input logic [NM-1:0] md);
    step(1'b1, 1'b0, tr, am, 1'b0, 1'b0, mr, md);
    step(1'b1, 1'b0, tr, am, 1'b0, 1'b0, mr, md);
    step(1'b1, 1'b1, tr, am, 1'b0, 1'b0, mr, md);
  endtask

  initial begin
    @(negedge clk);
    step(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 2'b11, 2'b00);
    step(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 2'b11, 2'b00);

    // Normal op: trigger, 1 ack tick, 5 wait ticks, update, done.
    upd_seen = 0;
    step(1'b1, 1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 2'b11, 2'b00);
    step(1'b1, 1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 2'b00, 2'b00);
    repeat (4) step(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00);
    step(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b11);
    repeat (3) step(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 2'b11, 2'b00);
    check("s1_update_pulses", 8'(upd_seen), 8'd1);

    // Staggered acks: motor0 on tick 1, motor1 on tick 3.
    step(1'b1, 1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 2'b11, 2'b00);
    step(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 2'b10, 2'b00);
    step(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 2'b10, 2'b00);
    step(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00);
    step(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b11);
    repeat (3) step(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 2'b11, 2'b00);

    // Empty mask goes straight to update_pos.
    step(1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00);
    repeat (3) step(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 2'b11, 2'b00);

    // Ack timeout, then error held until err_clear.
    step(1'b1, 1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 2'b11, 2'b00);
    repeat (4) step(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 2'b11, 2'b00);
    check("s4_err_code", 8'(err_code), 8'd1);
    step(1'b1, 1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 2'b11, 2'b00);
    step(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 2'b11, 2'b00);
    check("s4_rdy_after_clear", 8'(rdy), 8'd1);

    // Abort in WAIT: no update_pos, aborted sticks until next accepted trigger.
    upd_seen = 0;
    step(1'b1, 1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 2'b11, 2'b00);
    step(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00);
    step(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b01);
    step(1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 2'b00, 2'b00);
    step(1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 2'b11, 2'b00);
    step(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 2'b11, 2'b00);
    check("s5_no_update", 8'(upd_seen), 8'd0);
    check("s5_aborted", 8'(aborted), 8'd1);
    step(1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 2'b11, 2'b00);
    step(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b10);
    step(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b10);
    repeat (3) step(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 2'b11, 2'b00);

    // Done timeout.
    step(1'b1, 1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 2'b11, 2'b00);
    step(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00);
    repeat (DT) step(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00);
    check("done_tmo_code", 8'(err_code), 8'd2);
    step(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 2'b11, 2'b00);

    // Reset mid-WAIT while clk_en is low.
    step(1'b1, 1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 2'b11, 2'b00);
    step(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00);
    step(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00);
    step(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00);
    step(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b11, 2'b00);

    // Normal op with clk_en 1-in-3: every phase lasts exactly 3x.
    upd_seen = 0;
    step3(1'b1, 2'b11, 2'b11, 2'b00);
    step3(1'b0, 2'b11, 2'b00, 2'b00);
    repeat (4) step3(1'b0, 2'b00, 2'b00, 2'b00);
    step3(1'b0, 2'b00, 2'b00, 2'b11);
    repeat (3) step3(1'b0, 2'b00, 2'b11, 2'b00);
    check("s6_stretched_update", 8'(upd_seen), 8'd3);

    // Random stimulus.
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 199) != 0), ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           NM'($urandom), ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) == 0),
           NM'($urandom), (($urandom_range(0, 2) == 0) ? NM'($urandom) : {NM{1'b0}}));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
